// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU with a valid/ready handshake.
// Single-cycle ops (logic, add/sub, shifts, compares, pass) return their
// result one cycle after accept. MUL/MULHU/DIVU/REMU iterate one bit per
// cycle over a shared 2*WIDTH accumulator and return after WIDTH+1 cycles.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   valid_in, ready     request handshake; accept = valid_in && ready
//   kill                aborts an op that is already BUSY
//   control             opcode, sampled at accept
//   entrada0, entrada1  operands A and B, sampled at accept
//   valid_out           one-cycle pulse when saida/zero carry a new result
//   saida, zero         registered result and (result == 0), held until replaced
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             kill,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] entrada0,
  input  logic [WIDTH-1:0] entrada1,
  output logic             ready,
  output logic             valid_out,
  output logic [WIDTH-1:0] saida,
  output logic             zero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned AW  = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] op_q, op_d;
  // sel[1]: divide (else multiply); sel[0]: take upper accumulator half
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] saida_q, saida_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] alu_res_c;
  logic [SHW-1:0]   shamt_c;
  logic             is_multi_c;
  logic             accept_c;

  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   rem_sh_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] rem_new_c;
  logic [AW-1:0]    step_c;
  logic [WIDTH-1:0] step_res_c;

  // Single-cycle result, computed straight from the request operands
  always_comb begin
    shamt_c   = entrada1[SHW-1:0];
    alu_res_c = entrada0;
    case (control)
      4'b0000: alu_res_c = entrada0 & entrada1;
      4'b0001: alu_res_c = entrada0 | entrada1;
      4'b0010: alu_res_c = entrada0 + entrada1;
      4'b0011: alu_res_c = entrada0 ^ entrada1;
      4'b0100: alu_res_c = entrada0 << shamt_c;
      4'b0101: alu_res_c = entrada0 >> shamt_c;
      4'b0110: alu_res_c = entrada0 - entrada1;
      4'b0111: alu_res_c = WIDTH'($signed(entrada0) >>> shamt_c);
      4'b1000: alu_res_c = {{(WIDTH-1){1'b0}}, ($signed(entrada0) < $signed(entrada1))};
      4'b1001: alu_res_c = {{(WIDTH-1){1'b0}}, (entrada0 < entrada1)};
      default: alu_res_c = entrada0;
    endcase
  end

  // 1010 MUL, 1011 MULHU, 1100 DIVU, 1101 REMU
  assign is_multi_c = control[3] & (control[2] ^ control[1]);
  assign accept_c   = valid_in & (state_q != S_BUSY);

  // One iteration step. Multiply: acc = {hi, multiplier}, add A into hi
  // when the current multiplier bit is set, then shift right.
  // Divide: acc = {remainder, dividend}, restoring shift-subtract. A zero
  // divisor naturally yields quotient all-ones and remainder = dividend.
  always_comb begin
    mul_sum_c = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
    rem_sh_c  = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_c  = (rem_sh_c >= {1'b0, op_q});
    rem_new_c = div_ge_c ? WIDTH'(rem_sh_c - {1'b0, op_q}) : rem_sh_c[WIDTH-1:0];
    if (sel_q[1]) begin
      step_c = {rem_new_c, acc_q[WIDTH-2:0], div_ge_c};
    end else begin
      step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
    end
    step_res_c = sel_q[0] ? step_c[AW-1:WIDTH] : step_c[WIDTH-1:0];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    sel_d   = sel_q;
    saida_d = saida_q;
    zero_d  = zero_q;
    valid_d = 1'b0;

    case (state_q)
      S_BUSY: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_c;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            saida_d = step_res_c;
            zero_d  = (step_res_c == '0);
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - SHW'(1);
          end
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE->DONE gives back-to-back results
        if (accept_c) begin
          if (is_multi_c) begin
            state_d = S_BUSY;
            cnt_d   = SHW'(WIDTH - 1);
            sel_d   = {control[2], control[0]};
            op_d    = control[2] ? entrada1 : entrada0;
            acc_d   = control[2] ? {{WIDTH{1'b0}}, entrada0} : {{WIDTH{1'b0}}, entrada1};
          end else begin
            state_d = S_DONE;
            saida_d = alu_res_c;
            zero_d  = (alu_res_c == '0);
            valid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    ready_d = (state_d != S_BUSY);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      sel_q   <= '0;
      saida_q <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      saida_q <= saida_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign valid_out = valid_q;
  assign saida     = saida_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH=32). The driver pushes the
// model result and the cycle it is due; a negedge monitor pops and compares
// on every valid_out pulse.
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic         kill;
  logic [3:0]   control;
  logic [W-1:0] entrada0;
  logic [W-1:0] entrada1;
  logic         ready;
  logic         valid_out;
  logic [W-1:0] saida;
  logic         zero;

  typedef struct {
    logic [W-1:0] res;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks;
  int           n_errors;
  int           cyc;
  logic [W-1:0] last_res;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .kill     (kill),
    .control  (control),
    .entrada0 (entrada0),
    .entrada1 (entrada1),
    .ready    (ready),
    .valid_out(valid_out),
    .saida    (saida),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [4:0]     sh;
    sh = b[4:0];
    p  = 64'(a) * 64'(b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0110: return a - b;
      4'b0111: return W'($signed(a) >>> sh);
      4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: return (a < b) ? 32'd1 : 32'd0;
      4'b1010: return p[W-1:0];
      4'b1011: return p[2*W-1:W];
      4'b1100: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1101: return (b == 0) ? a : a % b;
      default: return a;
    endcase
  endfunction

  // Drive a request from a negedge, wait (bounded) for ready, let one edge accept it
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    exp_t e;
    int   budget;
    @(negedge clk);
    control  = c;
    entrada0 = a;
    entrada1 = b;
    valid_in = 1'b1;
    budget   = 100;
    while (!ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!ready) begin
      check_eq("ready_timeout", 32'(ready), 32'd1);
      valid_in = 1'b0;
      return;
    end
    if (push) begin
      e.res = model(c, a, b);
      e.due = cyc + 1 + ((c[3] && (c[2] ^ c[1])) ? W : 0);
      exp_q.push_back(e);
      last_res = e.res;
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_out) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'(valid_out), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("saida", saida, e.res);
        check_eq("zero", 32'(zero), 32'(e.res == 0));
        check_eq("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_res = '0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    kill     = 1'b0;
    control  = '0;
    entrada0 = '0;
    entrada1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_saida", saida, 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd0);

    // back-to-back single-cycle ops
    issue(4'b0110, 32'd5, 32'd5, 1'b1);
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(4'b0111, 32'h8000_0000, 32'd4, 1'b1);
    issue(4'b0101, 32'h8000_0000, 32'd4, 1'b1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(4'b1001, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(4'b0100, 32'h0000_0001, 32'd36, 1'b1);
    issue(4'b0101, 32'h8000_0000, 32'd36, 1'b1);
    issue(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1);
    issue(4'b1110, 32'h1234_5678, 32'd0, 1'b1);
    drain();

    // multiply, ready must stay low while busy
    issue(4'b1010, 32'h0001_0000, 32'h0001_0000, 1'b1);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      check_eq("busy_ready", 32'(ready), 32'd0);
    end
    issue(4'b1011, 32'h0001_0000, 32'h0001_0000, 1'b1);
    issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(4'b1100, 32'd100, 32'd7, 1'b1);
    issue(4'b1101, 32'd100, 32'd7, 1'b1);
    issue(4'b1100, 32'd5, 32'd0, 1'b1);
    issue(4'b1101, 32'd5, 32'd0, 1'b1);
    drain();

    // kill on cycle 10 of a divide
    issue(4'b1100, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check_eq("kill_ready", 32'(ready), 32'd1);
    check_eq("kill_saida", saida, last_res);
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1);
    drain();

    // async reset in the middle of a multiply
    issue(4'b1010, 32'd1234, 32'd5678, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("amid_rst_saida", saida, 32'd0);
    check_eq("amid_rst_ready", 32'(ready), 32'd1);
    check_eq("amid_rst_valid", 32'(valid_out), 32'd0);
    check_eq("amid_rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // random mix across all opcodes
    for (int i = 0; i < 24; i++) begin
      logic [3:0]   c;
      logic [W-1:0] a;
      logic [W-1:0] b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      issue(c, a, b, 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
